// File: rtl/scan_raster_gen.sv
// rtl/scan_raster_gen.sv - raster scan X/Y position, pixel dwell strobe and line/frame markers
module scan_raster_gen #(
    parameter int X_POINTS      = 256,
    parameter int Y_POINTS      = 256,
    parameter int POS_W         = 10,
    parameter int DWELL_CYCLES  = 100,
    parameter int SETTLE_CYCLES = 1000,
    parameter int SERPENTINE    = 0
) (
    input  logic             clk_100m,
    input  logic             reset_n,
    input  logic             run,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             pixel_strobe,
    output logic             line_start,
    output logic             frame_done,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DC_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [DC_W-1:0]  DWELL_LAST  = DC_W'(DWELL_CYCLES - 1);
    localparam logic [POS_W-1:0] X_LAST      = POS_W'(X_POINTS - 1);
    localparam logic [POS_W-1:0] Y_LAST      = POS_W'(Y_POINTS - 1);
    localparam bit               SERP        = (SERPENTINE != 0);

    typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;

    state_t           state, state_n;
    logic [SC_W-1:0]  settle_cnt, settle_n;
    logic [DC_W-1:0]  dwell_cnt, dwell_n;
    logic [POS_W-1:0] x_n, y_n;
    logic [15:0]      frame_n;
    logic             new_line, reverse, at_eol, rev_n, last_pix_n;
    logic             strobe_n, line_start_n, frame_done_n;

    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            dwell_cnt    <= '0;
            x_pos        <= '0;
            y_pos        <= '0;
            pixel_strobe <= 1'b0;
            line_start   <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            state        <= state_n;
            settle_cnt   <= settle_n;
            dwell_cnt    <= dwell_n;
            x_pos        <= x_n;
            y_pos        <= y_n;
            pixel_strobe <= strobe_n;
            line_start   <= line_start_n;
            frame_done   <= frame_done_n;
            busy         <= (state_n != IDLE);
            frame_cnt    <= frame_n;
        end
    end

    always_comb begin
        state_n  = state;
        settle_n = settle_cnt;
        dwell_n  = dwell_cnt;
        x_n      = x_pos;
        y_n      = y_pos;
        frame_n  = frame_cnt;
        new_line = 1'b0;
        reverse  = SERP && y_pos[0];
        at_eol   = reverse ? (x_pos == '0) : (x_pos == X_LAST);

        case (state)
            IDLE: begin
                x_n = '0;
                y_n = '0;
                if (run) begin
                    state_n  = SETTLE;
                    settle_n = '0;
                end
            end
            SETTLE: begin
                if (!run) begin
                    state_n  = IDLE;
                    settle_n = '0;
                    dwell_n  = '0;
                    x_n      = '0;
                    y_n      = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_n  = DWELL;
                    settle_n = '0;
                    dwell_n  = '0;
                    new_line = 1'b1;
                end else begin
                    settle_n = settle_cnt + SC_W'(1);
                end
            end
            DWELL: begin
                // The strobe for this pixel is already out, so a frame end completes even if run drops now.
                if (dwell_cnt == DWELL_LAST && at_eol && y_pos == Y_LAST) begin
                    frame_n  = frame_cnt + 16'd1;
                    x_n      = '0;
                    y_n      = '0;
                    dwell_n  = '0;
                    settle_n = '0;
                    state_n  = run ? SETTLE : IDLE;
                end else if (!run) begin
                    state_n  = IDLE;
                    settle_n = '0;
                    dwell_n  = '0;
                    x_n      = '0;
                    y_n      = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    dwell_n = '0;
                    if (!at_eol) begin
                        x_n = reverse ? x_pos - POS_W'(1) : x_pos + POS_W'(1);
                    end else begin
                        y_n      = y_pos + POS_W'(1);
                        x_n      = (SERP && y_n[0]) ? X_LAST : '0;
                        new_line = 1'b1;
                    end
                end else begin
                    dwell_n = dwell_cnt + DC_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                x_n     = '0;
                y_n     = '0;
            end
        endcase

        // Pulses are registered, so they are decoded from the values being loaded this edge.
        rev_n        = SERP && y_n[0];
        last_pix_n   = (y_n == Y_LAST) && (rev_n ? (x_n == '0) : (x_n == X_LAST));
        strobe_n     = (state_n == DWELL) && (dwell_n == DWELL_LAST);
        line_start_n = (state_n == DWELL) && new_line;
        frame_done_n = strobe_n && last_pix_n;
    end

endmodule

// File: tb/tb_scan_raster_gen.sv
// tb/tb_scan_raster_gen.sv - directed self-checking bench for scan_raster_gen
module tb_scan_raster_gen;

    localparam int XP    = 4;
    localparam int YP    = 3;
    localparam int PW    = 4;
    localparam int DW    = 2;
    localparam int SW    = 3;
    localparam int FRAME = SW + XP * YP * DW;
    localparam int VW    = 2 * PW + 20;

    logic          clk = 1'b0;
    logic          reset_n, run, reset_s, run_s;
    logic [PW-1:0] x_pos, y_pos, x_s, y_s;
    logic          pixel_strobe, line_start, frame_done, busy;
    logic          strobe_s, line_start_s, frame_done_s, busy_s;
    logic [15:0]   frame_cnt, frame_cnt_s;
    logic [VW-1:0] act, exp_v;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    scan_raster_gen #(
        .X_POINTS(XP), .Y_POINTS(YP), .POS_W(PW),
        .DWELL_CYCLES(DW), .SETTLE_CYCLES(SW), .SERPENTINE(0)
    ) dut (
        .clk_100m(clk), .reset_n(reset_n), .run(run),
        .x_pos(x_pos), .y_pos(y_pos), .pixel_strobe(pixel_strobe),
        .line_start(line_start), .frame_done(frame_done), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    scan_raster_gen #(
        .X_POINTS(XP), .Y_POINTS(YP), .POS_W(PW),
        .DWELL_CYCLES(DW), .SETTLE_CYCLES(SW), .SERPENTINE(1)
    ) dut_s (
        .clk_100m(clk), .reset_n(reset_s), .run(run_s),
        .x_pos(x_s), .y_pos(y_s), .pixel_strobe(strobe_s),
        .line_start(line_start_s), .frame_done(frame_done_s), .busy(busy_s),
        .frame_cnt(frame_cnt_s)
    );

    // Expected {x, y, strobe, line_start, frame_done, busy, frame_cnt} in cycle c of continuous running.
    function automatic logic [VW-1:0] expect_vec(input int c, input bit serp);
        int f, cl, d, k, ph, ex, ey;
        logic es, els, efd;
        f   = (c - 1) / FRAME;
        cl  = c - FRAME * f;
        ex  = 0;
        ey  = 0;
        es  = 1'b0;
        els = 1'b0;
        efd = 1'b0;
        if (cl > SW) begin
            d   = cl - SW - 1;
            k   = d / DW;
            ph  = d % DW;
            ey  = k / XP;
            ex  = (serp && (ey % 2 == 1)) ? (XP - 1 - k % XP) : (k % XP);
            es  = (ph == DW - 1);
            els = (ph == 0) && (k % XP == 0);
            efd = es && (k == XP * YP - 1);
        end
        return {PW'(ex), PW'(ey), es, els, efd, 1'b1, 16'(f)};
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic test_reset();
        do_reset();
        act = {x_pos, y_pos, pixel_strobe, line_start, frame_done, busy, frame_cnt};
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h expected 0", act);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1'b1;
        repeat (7) step();
        checks++;
        if (pixel_strobe !== 1'b1 || x_pos !== PW'(1)) begin
            failures++;
            $display("FAIL async_pre: strobe=%b x=%0d expected strobe=1 x=1", pixel_strobe, x_pos);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        act = {x_pos, y_pos, pixel_strobe, line_start, frame_done, busy, frame_cnt};
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h expected 0 before next edge", act);
        end
        @(negedge clk);
        run     = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_frame();
        int first_s = -1, second_s = -1, fd_cyc = -1, n1 = 0;
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            act   = {x_pos, y_pos, pixel_strobe, line_start, frame_done, busy, frame_cnt};
            exp_v = expect_vec(cyc, 1'b0);
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL frame_cyc%0d: got %h expected %h", cyc, act, exp_v);
            end
            if (pixel_strobe === 1'b1) begin
                if (cyc <= FRAME) n1++;
                if (first_s < 0) first_s = cyc;
                else if (cyc > FRAME && second_s < 0) second_s = cyc;
            end
            if (frame_done === 1'b1 && fd_cyc < 0) fd_cyc = cyc;
        end
        checks++;
        if (first_s != 5) begin
            failures++;
            $display("FAIL first_strobe: cycle %0d expected 5", first_s);
        end
        checks++;
        if (n1 != 12) begin
            failures++;
            $display("FAIL strobe_count: got %0d expected 12", n1);
        end
        checks++;
        if (fd_cyc != 27) begin
            failures++;
            $display("FAIL frame_done_cycle: got %0d expected 27", fd_cyc);
        end
        checks++;
        if (second_s != 32) begin
            failures++;
            $display("FAIL second_frame_strobe: got %0d expected 32", second_s);
        end
        run = 1'b0;
    endtask

    task automatic test_serpentine();
        int n_ls = 0;
        reset_s = 1'b0;
        run_s   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_s = 1'b1;
        cyc     = 0;
        run_s   = 1'b1;
        for (int c = 1; c <= FRAME; c++) begin
            step();
            act   = {x_s, y_s, strobe_s, line_start_s, frame_done_s, busy_s, frame_cnt_s};
            exp_v = expect_vec(cyc, 1'b1);
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL serp_cyc%0d: got %h expected %h", cyc, act, exp_v);
            end
            if (line_start_s === 1'b1) n_ls++;
        end
        checks++;
        if (n_ls != 3) begin
            failures++;
            $display("FAIL serp_line_starts: got %0d expected 3", n_ls);
        end
        run_s = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int s_cyc = -1;
        do_reset();
        run = 1'b1;
        repeat (16) step();
        checks++;
        if (x_pos !== PW'(2) || y_pos !== PW'(1) || pixel_strobe !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: x=%0d y=%0d strobe=%b busy=%b expected x=2 y=1 strobe=0 busy=1",
                     x_pos, y_pos, pixel_strobe, busy);
        end
        run = 1'b0;
        step();
        act = {x_pos, y_pos, pixel_strobe, line_start, frame_done, busy, frame_cnt};
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL abort_idle: got %h expected 0", act);
        end
        run = 1'b1;
        for (int i = 0; i < 20 && s_cyc < 0; i++) begin
            step();
            if (pixel_strobe === 1'b1) s_cyc = cyc;
        end
        checks++;
        if (s_cyc != 22 || x_pos !== '0 || y_pos !== '0) begin
            failures++;
            $display("FAIL abort_restart: strobe cycle %0d at (%0d,%0d) expected 22 at (0,0)",
                     s_cyc, x_pos, y_pos);
        end
        run = 1'b0;
    endtask

    task automatic test_frame_end_abort();
        do_reset();
        run = 1'b1;
        repeat (26) step();
        run = 1'b0;
        step();
        checks++;
        if (pixel_strobe !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL last_pixel_abort: strobe=%b done=%b busy=%b expected 0 0 0",
                     pixel_strobe, frame_done, busy);
        end
        repeat (3) step();
        checks++;
        if (frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL last_pixel_abort_cnt: got %0d expected 0", frame_cnt);
        end

        do_reset();
        run = 1'b1;
        repeat (27) step();
        checks++;
        if (frame_done !== 1'b1 || pixel_strobe !== 1'b1) begin
            failures++;
            $display("FAIL late_drop_done: done=%b strobe=%b expected 1 1", frame_done, pixel_strobe);
        end
        run = 1'b0;
        step();
        act = {x_pos, y_pos, pixel_strobe, line_start, frame_done, busy, frame_cnt};
        checks++;
        if (act !== {{(2*PW+4){1'b0}}, 16'd1}) begin
            failures++;
            $display("FAIL late_drop_idle: got %h expected frame_cnt=1 rest 0", act);
        end
        step();
        checks++;
        if (busy !== 1'b0 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL late_drop_stay: busy=%b cnt=%0d expected 0 1", busy, frame_cnt);
        end
    endtask

    task automatic test_frame_cnt_wrap();
        do_reset();
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        checks++;
        if (frame_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload: got %h expected ffff", frame_cnt);
        end
        cyc = 0;
        run = 1'b1;
        repeat (27) step();
        checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_done: done=%b cnt=%h expected 1 ffff", frame_done, frame_cnt);
        end
        step();
        checks++;
        if (frame_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_cnt: got %h expected 0000", frame_cnt);
        end
        run = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        reset_s = 1'b0;
        run_s   = 1'b0;
        test_reset();
        test_async_reset();
        test_frame();
        test_serpentine();
        test_abort();
        test_frame_end_abort();
        test_frame_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
